// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Purpose  : Multi-channel PWM with prescaler and period-boundary sample load.
// Revision : 1.0
// ============================================================================
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int PRESCALE = 1
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] sample,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic [CHANNELS-1:0]       pwm_o,
    output logic                      period_strobe,
    output logic                      underrun
);

    localparam int               c_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0]  c_PRE_LAST = c_PW'(PRESCALE - 1);
    localparam logic [c_PW-1:0]  c_PRE_ONE  = c_PW'(1);
    localparam logic [WIDTH-1:0] c_MAX      = '1;
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

    logic [c_PW-1:0]           r_presc;
    logic [WIDTH-1:0]          r_count;
    logic [CHANNELS*WIDTH-1:0] r_shadow;
    logic [CHANNELS*WIDTH-1:0] r_active;
    logic                      r_pending;
    logic                      r_strobe;
    logic                      r_underrun;
    logic [CHANNELS-1:0]       r_pwm;

    logic                      w_tick;
    logic                      w_wrap;
    logic                      w_accept;
    logic [c_PW-1:0]           w_presc_next;
    logic [WIDTH-1:0]          w_count_next;
    logic [CHANNELS*WIDTH-1:0] w_active_next;
    logic [CHANNELS-1:0]       w_pwm_next;

    assign w_tick        = (r_presc == c_PRE_LAST);
    assign w_wrap        = en && w_tick && (r_count == c_MAX);
    assign w_accept      = sample_valid && !r_pending;
    assign w_presc_next  = (!en || w_tick) ? '0 : r_presc + c_PRE_ONE;
    assign w_count_next  = !en ? '0 : (w_tick ? r_count + c_ONE : r_count);
    assign w_active_next = (w_wrap && r_pending) ? r_shadow : r_active;

    // Compare against next-state values so pwm_o lines up with the registered count.
    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_ch
            assign w_pwm_next[c] = en && (w_count_next < w_active_next[c*WIDTH +: WIDTH]);
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_presc    <= '0;
            r_count    <= '0;
            r_shadow   <= '0;
            r_active   <= '0;
            r_pending  <= 1'b0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
            r_pwm      <= '0;
        end else begin
            r_presc    <= w_presc_next;
            r_count    <= w_count_next;
            r_active   <= w_active_next;
            r_strobe   <= w_wrap;
            r_underrun <= w_wrap && !r_pending;
            r_pwm      <= w_pwm_next;
            // Accept needs pending clear, so it never collides with a consuming wrap.
            if (w_accept) begin
                r_shadow  <= sample;
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign sample_ready  = !r_pending;
    assign pwm_o         = r_pwm;
    assign period_strobe = r_strobe;
    assign underrun      = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi
// Purpose  : Directed self-checking bench for pwm_multi (PRESCALE 1 and 4).
// Revision : 1.0
// ============================================================================
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        en1, val1, en4, val4;
    logic [15:0] smp1, smp4;
    logic        rdy1, stb1, und1, rdy4, stb4, und4;
    logic [1:0]  pwm1, pwm4;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pwm_multi #(.WIDTH(8), .CHANNELS(2), .PRESCALE(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .en(en1), .sample(smp1), .sample_valid(val1),
        .sample_ready(rdy1), .pwm_o(pwm1), .period_strobe(stb1), .underrun(und1));

    pwm_multi #(.WIDTH(8), .CHANNELS(2), .PRESCALE(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .en(en4), .sample(smp4), .sample_valid(val4),
        .sample_ready(rdy4), .pwm_o(pwm4), .period_strobe(stb4), .underrun(und4));

    // Advances one negedge at a time until the selected strobe is seen.
    task automatic wait_strobe(input bit which, output int n);
        logic s;
        n = 0;
        s = 1'b0;
        while (!s && n < 5000) begin
            @(negedge clk);
            n++;
            s = which ? stb4 : stb1;
        end
        checks++;
        if (!s) begin
            errors++;
            $display("FAIL strobe_timeout dut%0d: no strobe within %0d cycles", which ? 4 : 1, n);
        end
    endtask

    // Gathers statistics over len cycles starting at the current negedge.
    task automatic measure(input bit which, input int len, output int h0, output int h1,
                           output int ns, output int nu, output logic [1:0] first,
                           output logic [1:0] last);
        logic [1:0] p;
        h0 = 0; h1 = 0; ns = 0; nu = 0; first = '0; last = '0;
        for (int i = 0; i < len; i++) begin
            p = which ? pwm4 : pwm1;
            if (i == 0)       first = p;
            if (i == len - 1) last  = p;
            h0 += int'(p[0]);
            h1 += int'(p[1]);
            ns += int'(which ? stb4 : stb1);
            nu += int'(which ? und4 : und1);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0; en1 = 1'b0; en4 = 1'b0;
        val1 = 1'b0; val4 = 1'b0; smp1 = '0; smp4 = '0;
        repeat (3) @(negedge clk);
        checks++; if (pwm1 !== 2'b00) begin errors++; $display("FAIL rst_pwm1 got %b expected 00", pwm1); end
        checks++; if (rdy1 !== 1'b1)  begin errors++; $display("FAIL rst_ready1 got %b expected 1", rdy1); end
        checks++; if (stb1 !== 1'b0)  begin errors++; $display("FAIL rst_strobe1 got %b expected 0", stb1); end
        checks++; if (und1 !== 1'b0)  begin errors++; $display("FAIL rst_underrun1 got %b expected 0", und1); end
        checks++; if (rdy4 !== 1'b1)  begin errors++; $display("FAIL rst_ready4 got %b expected 1", rdy4); end
        checks++; if (pwm4 !== 2'b00) begin errors++; $display("FAIL rst_pwm4 got %b expected 00", pwm4); end
    endtask

    task automatic test_basic;
        int n, h0, h1, ns, nu;
        logic [1:0] f, l;
        n_rst = 1'b1; en1 = 1'b1;
        wait_strobe(1'b0, n);
        checks++; if (n !== 256) begin errors++; $display("FAIL first_wrap_time got %0d expected 256", n); end
        checks++; if (und1 !== 1'b1) begin errors++; $display("FAIL first_underrun got %b expected 1", und1); end
        smp1 = {8'd128, 8'd0}; val1 = 1'b1;
        measure(1'b0, 256, h0, h1, ns, nu, f, l);
        checks++; if (h1 !== 0) begin errors++; $display("FAIL idle_period_ch1 got %0d expected 0", h1); end
        checks++; if (stb1 !== 1'b1) begin errors++; $display("FAIL wrap2_strobe got %b expected 1", stb1); end
        checks++; if (und1 !== 1'b0) begin errors++; $display("FAIL wrap2_underrun got %b expected 0", und1); end
        measure(1'b0, 256, h0, h1, ns, nu, f, l);
        checks++; if (h0 !== 0)   begin errors++; $display("FAIL basic_ch0_high got %0d expected 0", h0); end
        checks++; if (h1 !== 128) begin errors++; $display("FAIL basic_ch1_high got %0d expected 128", h1); end
        checks++; if (ns !== 1)   begin errors++; $display("FAIL basic_strobes got %0d expected 1", ns); end
        checks++; if (nu !== 0)   begin errors++; $display("FAIL basic_underruns got %0d expected 0", nu); end
        checks++; if (stb1 !== 1'b1) begin errors++; $display("FAIL basic_period got %b expected strobe 1", stb1); end
        checks++; if (und1 !== 1'b0) begin errors++; $display("FAIL wrap3_underrun got %b expected 0", und1); end
    endtask

    task automatic test_extremes;
        int h0, h1, ns, nu;
        logic [1:0] f, l;
        smp1 = {8'd1, 8'd255};
        measure(1'b0, 256, h0, h1, ns, nu, f, l);
        measure(1'b0, 256, h0, h1, ns, nu, f, l);
        checks++; if (h0 !== 255)  begin errors++; $display("FAIL ext_ch0_high got %0d expected 255", h0); end
        checks++; if (h1 !== 1)    begin errors++; $display("FAIL ext_ch1_high got %0d expected 1", h1); end
        checks++; if (f !== 2'b11) begin errors++; $display("FAIL ext_count0 got %b expected 11", f); end
        checks++; if (l !== 2'b00) begin errors++; $display("FAIL ext_count255 got %b expected 00", l); end
        smp1 = {8'd64, 8'd64};
        @(negedge clk);
        val1 = 1'b0;
    endtask

    task automatic test_mid_update;
        int n, h0, h1, ns, nu;
        logic [1:0] f, l;
        wait_strobe(1'b0, n);
        h0 = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL mid_ready_before got %b expected 1", rdy1); end
                smp1 = {8'd200, 8'd200}; val1 = 1'b1;
            end
            if (i == 101) begin
                val1 = 1'b0;
                checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL mid_ready_drop got %b expected 0", rdy1); end
            end
            h0 += int'(pwm1[0]);
            @(negedge clk);
        end
        checks++; if (h0 !== 64)      begin errors++; $display("FAIL mid_old_duty got %0d expected 64", h0); end
        checks++; if (stb1 !== 1'b1)  begin errors++; $display("FAIL mid_wrap_strobe got %b expected 1", stb1); end
        checks++; if (rdy1 !== 1'b1)  begin errors++; $display("FAIL mid_ready_rise got %b expected 1", rdy1); end
        checks++; if (pwm1 !== 2'b11) begin errors++; $display("FAIL mid_new_at_0 got %b expected 11", pwm1); end
        measure(1'b0, 256, h0, h1, ns, nu, f, l);
        checks++; if (h0 !== 200) begin errors++; $display("FAIL mid_new_ch0 got %0d expected 200", h0); end
        checks++; if (h1 !== 200) begin errors++; $display("FAIL mid_new_ch1 got %0d expected 200", h1); end
        checks++; if (und1 !== 1'b1) begin errors++; $display("FAIL mid_no_sample_underrun got %b expected 1", und1); end
    endtask

    task automatic test_same_cycle;
        int h0, h1, ns, nu;
        logic [1:0] f, l;
        repeat (255) @(negedge clk);
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL sc_ready got %b expected 1", rdy1); end
        smp1 = {8'd150, 8'd150}; val1 = 1'b1;
        @(negedge clk);
        val1 = 1'b0;
        checks++; if (stb1 !== 1'b1) begin errors++; $display("FAIL sc_strobe got %b expected 1", stb1); end
        checks++; if (und1 !== 1'b1) begin errors++; $display("FAIL sc_underrun got %b expected 1", und1); end
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL sc_accepted got %b expected ready 0", rdy1); end
        measure(1'b0, 256, h0, h1, ns, nu, f, l);
        checks++; if (h0 !== 200) begin errors++; $display("FAIL sc_old_kept got %0d expected 200", h0); end
        checks++; if (und1 !== 1'b0) begin errors++; $display("FAIL sc_next_wrap_underrun got %b expected 0", und1); end
        measure(1'b0, 256, h0, h1, ns, nu, f, l);
        checks++; if (h0 !== 150) begin errors++; $display("FAIL sc_new_ch0 got %0d expected 150", h0); end
        checks++; if (h1 !== 150) begin errors++; $display("FAIL sc_new_ch1 got %0d expected 150", h1); end
    endtask

    task automatic test_reset_mid;
        int n, h0, h1, ns, nu;
        logic [1:0] f, l;
        smp1 = {8'd99, 8'd99}; val1 = 1'b1;
        @(negedge clk);
        val1 = 1'b0;
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL rm_pending got %b expected ready 0", rdy1); end
        repeat (76) @(negedge clk);
        checks++; if (pwm1 !== 2'b11) begin errors++; $display("FAIL rm_pwm_before got %b expected 11", pwm1); end
        n_rst = 1'b0;
        #1;
        checks++; if (pwm1 !== 2'b00) begin errors++; $display("FAIL rm_pwm_async got %b expected 00", pwm1); end
        checks++; if (rdy1 !== 1'b1)  begin errors++; $display("FAIL rm_ready_async got %b expected 1", rdy1); end
        checks++; if (stb1 !== 1'b0)  begin errors++; $display("FAIL rm_strobe got %b expected 0", stb1); end
        checks++; if (und1 !== 1'b0)  begin errors++; $display("FAIL rm_underrun got %b expected 0", und1); end
        @(negedge clk);
        n_rst = 1'b1;
        wait_strobe(1'b0, n);
        checks++; if (n !== 256)     begin errors++; $display("FAIL rm_wrap_time got %0d expected 256", n); end
        checks++; if (und1 !== 1'b1) begin errors++; $display("FAIL rm_underrun_after got %b expected 1", und1); end
        measure(1'b0, 256, h0, h1, ns, nu, f, l);
        checks++; if (h0 + h1 !== 0) begin errors++; $display("FAIL rm_active_zero got %0d expected 0", h0 + h1); end
    endtask

    task automatic test_prescale;
        int n, h0, h1, ns, nu;
        logic [1:0] f, l;
        smp4 = {8'd128, 8'd128}; val4 = 1'b1;
        @(negedge clk);
        val4 = 1'b0;
        checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL ps_accept_en_low got %b expected ready 0", rdy4); end
        en4 = 1'b1;
        wait_strobe(1'b1, n);
        checks++; if (n !== 1024)    begin errors++; $display("FAIL ps_first_wrap got %0d expected 1024", n); end
        checks++; if (und4 !== 1'b0) begin errors++; $display("FAIL ps_load_underrun got %b expected 0", und4); end
        measure(1'b1, 1024, h0, h1, ns, nu, f, l);
        checks++; if (h0 !== 512) begin errors++; $display("FAIL ps_ch0_high got %0d expected 512", h0); end
        checks++; if (h1 !== 512) begin errors++; $display("FAIL ps_ch1_high got %0d expected 512", h1); end
        checks++; if (ns !== 1)   begin errors++; $display("FAIL ps_strobes got %0d expected 1", ns); end
        checks++; if (stb4 !== 1'b1) begin errors++; $display("FAIL ps_period got %b expected strobe 1", stb4); end
        repeat (300) @(negedge clk);
        checks++; if (pwm4 !== 2'b11) begin errors++; $display("FAIL ps_pwm_before_drop got %b expected 11", pwm4); end
        en4 = 1'b0;
        @(negedge clk);
        checks++; if (pwm4 !== 2'b00) begin errors++; $display("FAIL ps_pwm_after_drop got %b expected 00", pwm4); end
        measure(1'b1, 2100, h0, h1, ns, nu, f, l);
        checks++; if (ns + nu !== 0)  begin errors++; $display("FAIL ps_disabled_events got %0d expected 0", ns + nu); end
        checks++; if (h0 + h1 !== 0)  begin errors++; $display("FAIL ps_disabled_pwm got %0d expected 0", h0 + h1); end
        en4 = 1'b1;
        wait_strobe(1'b1, n);
        checks++; if (n !== 1024)    begin errors++; $display("FAIL ps_rerun_wrap got %0d expected 1024", n); end
        checks++; if (und4 !== 1'b1) begin errors++; $display("FAIL ps_rerun_underrun got %b expected 1", und4); end
        measure(1'b1, 1024, h0, h1, ns, nu, f, l);
        checks++; if (h0 !== 512) begin errors++; $display("FAIL ps_rerun_high got %0d expected 512", h0); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_extremes;
        test_mid_update;
        test_same_cycle;
        test_reset_mid;
        test_prescale;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator for the synth audio output path. It converts one WIDTH-bit sample per channel into a fixed-frequency pulse-width-modulated output, with a configurable clock prescaler. New samples are accepted through a valid/ready handshake into a shadow register and only take effect at a period boundary, so the output is glitch-free. A per-period strobe and an underrun flag let the upstream sample source pace itself.

## Interface
- WIDTH, 8: sample / duty resolution in bits; the period is 2^WIDTH counter steps.
- CHANNELS, 2: number of independent PWM outputs sharing one period counter.
- PRESCALE, 1: clocks per counter step; must be ≥1.

- clk  in  1  system clock; all state is on the rising edge.
- n_rst  in  1  reset, asynchronous and active-low; clears all state.
- en  in  1  run enable; when low, the counters are held at 0 and the outputs are low.
- sample  in  CHANNELS*WIDTH  packed duty values; channel c is at bits [c*WIDTH +: WIDTH].
- sample_valid  in  1  the upstream source offers `sample`.
- sample_ready  out  1  the shadow register is empty and can accept a sample.
- pwm_o  out  CHANNELS  registered PWM outputs.
- period_strobe  out  1  one-clock pulse at each period wrap.
- underrun  out  1  one-clock pulse when a wrap occurs with no pending sample.

## Operation
- **Prescaler:** counts 0..PRESCALE-1 while `en` is high. `tick` is high when the prescaler is at PRESCALE-1, and the prescaler then returns to 0. With PRESCALE=1, `tick` is high every clock.
- **Period counter:** WIDTH bits. It advances by 1 on each `tick` and wraps from MAX = 2^WIDTH-1 to 0. The wrap event is `tick && count==MAX && en`.
- **Shadow register and `pending` flag:**
  - `sample_ready = !pending`.
  - On `sample_valid && sample_ready`: shadow ← sample, pending ← 1.
- **On a wrap event:**
  - If pending: active ← shadow and pending ← 0.
  - If not pending: active holds its value and `underrun` pulses.
  - `period_strobe` pulses in either case.
- **Same-cycle accept and wrap:** an accept can only happen when pending=0. The accepted sample goes to the shadow register, and that wrap is an underrun (the previous active value is kept). The new sample loads at the following wrap.
- **Output compare:** `pwm_o[c] = en && (count < active[c])`, registered so that it is aligned with the registered count. Unsigned compare, full WIDTH.
  - duty 0 gives constant low.
  - duty D gives D high steps per 2^WIDTH steps.
  - the maximum duty gives 2^WIDTH-1 high steps, so the output is never constant high.
- **`en` low:**
  - The prescaler and count are held at 0, and `pwm_o` is 0.
  - No wrap events occur, so there are no strobes and no underruns.
  - The handshake still accepts into the shadow register; pending and active are retained.
- **`en` rising:** the period starts at count 0 on that clock. The first wrap occurs after PRESCALE*2^WIDTH clocks.

## Timing
- **Reset values:**
  - pwm_o=0, sample_ready=1, period_strobe=0, underrun=0.
  - count=0, prescaler=0, active=0, shadow=0, pending=0.
- **Reset mid-period:** all state returns to the reset values immediately (asynchronous), and any pending sample is discarded.
- **Period length:** PRESCALE*2^WIDTH clocks. Each count value lasts PRESCALE clocks.
- **`period_strobe` / `underrun`:** asserted in the clock cycle immediately after the wrap edge, i.e. the first cycle with count=0.
- **New duty timing:** a new active value is visible on `pwm_o` in the first cycle with count=0 after the wrap.
- **Handshake latency:**
  - `sample_ready` falls in the cycle after the accept.
  - `sample_ready` rises in the cycle after the wrap that consumes the shadow register.
  - A transfer completes at most once per period.
- **`en` falling:** `pwm_o` is 0 on the next cycle.

## Test plan
- **Reset and basic duty:** WIDTH=8, PRESCALE=1, CHANNELS=2. Release reset, load ch0=0, ch1=128, hold en=1.
  - Required: ch0 stays low.
  - Required: ch1 is high for 128 of every 256 clocks.
  - Required: period_strobe every 256 clocks; underrun on the first wrap only.
- **Extremes:** ch0=255, ch1=1.
  - Required: ch0 is high 255 of 256 clocks (low only at count 255).
  - Required: ch1 is high only at count 0.
- **Mid-period update:** with active=64, offer 200 at count 100.
  - Required: `sample_ready` drops next cycle.
  - Required: the output keeps 64-step pulses until the wrap; the 200-step pulse starts at count 0.
  - Required: `sample_ready` rises after the wrap.
- **Underrun and same-cycle accept:** offer a sample exactly on the wrap cycle with pending=0.
  - Required: underrun pulses and the old duty is kept for that period.
  - Required: the new duty appears one period later.
- **Prescaler and enable:** PRESCALE=4.
  - Required: period = 1024 clocks; duty 128 gives 512 high clocks.
  - Drop en mid-period. Required: pwm_o=0 next cycle, count=0, and no strobes.
  - Re-raise en. Required: a full period is produced from count 0.
- **Reset mid-operation:** assert n_rst low at count 77 with pending=1.
  - Required: all outputs reach their reset values immediately.
  - Required: after release, the first wrap flags underrun and active=0.
